latch_ex_mem: RTL and testbench
===============================

// Module: latch_ex_mem
// PURPOSE
//  EX/MEM pipeline register of the 5-stage MIPS core. Captures EX results: ALU result, store data, PC+8,
//  destination register from the rt/rd select mux, and MEM/WB control bits. Feeds the MEM stage and the
//  forwarding unit. Supports debug single-step, stall, flush and a sticky halt marker.
// PARAMETERS
//  BITS_SIZE  32  datapath width (ALU result, store data, PC+8)
//  BITS_REGS  5   register-address width
// PORTS
//  i_clk             in   1          core clock, all state on rising edge
//  i_rst_n           in   1          asynchronous, active-low reset
//  i_step            in   1          debug-unit enable; no state changes while 0
//  i_stall           in   1          hold all registered values
//  i_flush           in   1          insert bubble
//  i_valid           in   1          EX stage holds a real instruction
//  i_mux_register_rd in   BITS_REGS  destination register selected by the rt/rd mux
//  i_alu_result      in   BITS_SIZE  ALU output / effective address
//  i_rt_data         in   BITS_SIZE  store data
//  i_pc8             in   BITS_SIZE  PC+8 (JAL/JALR link value)
//  i_reg_write       in   1          WB writes register file
//  i_mem_to_reg      in   2          WB source: 00 ALU, 01 memory, 10 PC+8
//  i_mem_read        in   1          load
//  i_mem_write       in   1          store
//  i_mem_width       in   2          00 byte, 01 half, 11 word
//  i_mem_unsigned    in   1          zero-extend load
//  i_halt            in   1          HALT instruction in EX
//  o_valid, o_register_rd, o_alu_result, o_rt_data, o_pc8, o_reg_write, o_mem_to_reg, o_mem_read,
//  o_mem_write, o_mem_width, o_mem_unsigned   out  (same widths as inputs)  registered copies
//  o_halt            out  1          sticky halt flag toward MEM/WB and debug unit
// BEHAVIOUR
//  - Reset (i_rst_n=0, async): every output 0, including o_halt. Release is synchronous to the next edge.
//  - Latency: 1 cycle. Inputs seen at edge N appear on outputs after edge N.
//  - Edge action, priority order:
//    1. i_step=0: hold everything (flush and stall ignored).
//    2. i_flush=1: bubble. o_valid, o_reg_write, o_mem_read, o_mem_write and o_mem_to_reg go to 0.
//       Datapath outputs o_alu_result, o_rt_data, o_pc8 and o_register_rd also go to 0.
//       o_halt keeps its value. Flush beats stall.
//    3. i_stall=1: hold everything.
//    4. Otherwise: capture all inputs.
//  - Control qualification on capture:
//    - o_reg_write = i_reg_write & i_valid & (i_mux_register_rd != 0). $zero is never written.
//    - o_mem_read and o_mem_write are gated by i_valid.
//    - A store and a load in the same word: if i_mem_read and i_mem_write are both 1, write wins and
//      o_mem_read = 0.
//  - Halt: o_halt sets on a capture edge with i_halt & i_valid. It stays 1 until reset. Once set:
//    - later captures force o_valid=0, o_reg_write=0, o_mem_write=0, o_mem_read=0;
//    - data fields still update.
//  - No arithmetic; all fields pass through at native width, no extension.
//  - Reset mid-stall or mid-flush: reset wins immediately; the pipeline restarts empty.
// STRUCTURE
//  - Shared package/header (mips_defs) holds:
//    - WB_SRC_ALU=2'b00, WB_SRC_MEM=2'b01, WB_SRC_PC8=2'b10;
//    - MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b11;
//    - BITS_SIZE and BITS_REGS defaults.
//  - Single module: one async-reset always block plus a combinational qualify block. No sub-module.
// TESTING
//  1. Reset mid-run: drive valid capture (alu=32'hDEAD_BEEF, rd=5'd8, reg_write=1); assert i_rst_n=0 between
//     edges -> all outputs 0 immediately, before the next edge.
//  2. Normal capture with step=1: rd=5'd9, alu=32'h0000_0010, mem_to_reg=01, mem_read=1 -> one edge later
//     o_register_rd=9, o_alu_result=16, o_mem_read=1, o_valid=1.
//  3. $zero write: rd=0, reg_write=1, valid=1 -> o_reg_write=0 with o_valid=1.
//     Repeat with valid=0 -> o_mem_write=0 and o_reg_write=0.
//  4. Stall vs flush: capture rd=5, then stall=1 for 3 edges with changing inputs -> outputs stay rd=5.
//     Then stall=1 and flush=1 together -> bubble: o_valid=0, o_register_rd=0.
//  5. Step gating: step=0 with flush=1 and new inputs for 4 edges -> no output change.
//     Then step=1 -> capture occurs.
//  6. Halt: capture with i_halt=1, valid=1 -> o_halt=1. Next capture of a valid store
//     -> o_mem_write=0, o_valid=0, o_halt remains 1. Flush -> o_halt still 1. Reset -> o_halt=0.

Source files
------------

// File: rtl/latch_ex_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_defs
//  Shared definitions for the 5-stage MIPS core pipeline registers.
//  - Write-back source select encodings (WB_SRC_*)
//  - Memory access width encodings (MEM_*)
//  - Default datapath and register-address widths
// -----------------------------------------------------------------------------
package mips_defs;

   localparam int DEF_BITS_SIZE = 32;
   localparam int DEF_BITS_REGS = 5;

   // Write-back source select
   localparam logic [1:0] WB_SRC_ALU = 2'b00;
   localparam logic [1:0] WB_SRC_MEM = 2'b01;
   localparam logic [1:0] WB_SRC_PC8 = 2'b10;

   // Memory access width
   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b11;

endpackage

// File: rtl/latch_ex_mem.sv
// -----------------------------------------------------------------------------
// latch_ex_mem
//  EX/MEM pipeline register. Captures the EX-stage results (ALU result, store
//  data, PC+8, destination register) and the MEM/WB control bits, and presents
//  them to the MEM stage and the forwarding unit one cycle later.
//
//  Edge action priority: step gate (hold) > flush (bubble) > stall (hold) >
//  capture. A sticky halt flag is set by a valid HALT and is only cleared by
//  reset; while it is set, captured instructions are neutralised.
//
//  Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_step                debug-unit enable; nothing changes while 0
//   i_stall / i_flush     hold / insert bubble
//   i_valid               EX holds a real instruction
//   i_mux_register_rd     destination register
//   i_alu_result          ALU output / effective address
//   i_rt_data             store data
//   i_pc8                 link value for JAL/JALR
//   i_reg_write .. i_mem_unsigned   MEM/WB control
//   i_halt                HALT instruction in EX
//   o_*                   registered copies; o_halt is the sticky halt flag
// -----------------------------------------------------------------------------
module latch_ex_mem
   import mips_defs::*;
#(
   parameter int BITS_SIZE = DEF_BITS_SIZE,
   parameter int BITS_REGS = DEF_BITS_REGS
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_step,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic                 i_valid,
   input  logic [BITS_REGS-1:0] i_mux_register_rd,
   input  logic [BITS_SIZE-1:0] i_alu_result,
   input  logic [BITS_SIZE-1:0] i_rt_data,
   input  logic [BITS_SIZE-1:0] i_pc8,
   input  logic                 i_reg_write,
   input  logic [1:0]           i_mem_to_reg,
   input  logic                 i_mem_read,
   input  logic                 i_mem_write,
   input  logic [1:0]           i_mem_width,
   input  logic                 i_mem_unsigned,
   input  logic                 i_halt,
   output logic                 o_valid,
   output logic [BITS_REGS-1:0] o_register_rd,
   output logic [BITS_SIZE-1:0] o_alu_result,
   output logic [BITS_SIZE-1:0] o_rt_data,
   output logic [BITS_SIZE-1:0] o_pc8,
   output logic                 o_reg_write,
   output logic [1:0]           o_mem_to_reg,
   output logic                 o_mem_read,
   output logic                 o_mem_write,
   output logic [1:0]           o_mem_width,
   output logic                 o_mem_unsigned,
   output logic                 o_halt
);

   logic                 r_valid;
   logic [BITS_REGS-1:0] r_register_rd;
   logic [BITS_SIZE-1:0] r_alu_result;
   logic [BITS_SIZE-1:0] r_rt_data;
   logic [BITS_SIZE-1:0] r_pc8;
   logic                 r_reg_write;
   logic [1:0]           r_mem_to_reg;
   logic                 r_mem_read;
   logic                 r_mem_write;
   logic [1:0]           r_mem_width;
   logic                 r_mem_unsigned;
   logic                 r_halt;

   logic w_live;
   logic w_valid;
   logic w_reg_write;
   logic w_mem_read;
   logic w_mem_write;
   logic w_halt_set;

   // Qualified control for a capture edge. The halt flag used here is the one
   // already registered, so the HALT instruction itself still passes through
   // as valid; only instructions captured after it are neutralised.
   always_comb begin
      w_live      = i_valid & ~r_halt;
      w_valid     = w_live;
      // $zero is never a write target
      w_reg_write = i_reg_write & w_live & (i_mux_register_rd != '0);
      w_mem_write = i_mem_write & w_live;
      // read+write in one instruction resolves to a store
      w_mem_read  = i_mem_read & ~i_mem_write & w_live;
      w_halt_set  = i_halt & i_valid;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid        <= 1'b0;
         r_register_rd  <= '0;
         r_alu_result   <= '0;
         r_rt_data      <= '0;
         r_pc8          <= '0;
         r_reg_write    <= 1'b0;
         r_mem_to_reg   <= WB_SRC_ALU;
         r_mem_read     <= 1'b0;
         r_mem_write    <= 1'b0;
         r_mem_width    <= MEM_BYTE;
         r_mem_unsigned <= 1'b0;
         r_halt         <= 1'b0;
      end else if (i_step) begin
         if (i_flush) begin
            // Bubble: control and datapath cleared; width/unsigned and halt kept
            r_valid       <= 1'b0;
            r_register_rd <= '0;
            r_alu_result  <= '0;
            r_rt_data     <= '0;
            r_pc8         <= '0;
            r_reg_write   <= 1'b0;
            r_mem_to_reg  <= WB_SRC_ALU;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
         end else if (!i_stall) begin
            r_valid        <= w_valid;
            r_register_rd  <= i_mux_register_rd;
            r_alu_result   <= i_alu_result;
            r_rt_data      <= i_rt_data;
            r_pc8          <= i_pc8;
            r_reg_write    <= w_reg_write;
            r_mem_to_reg   <= i_mem_to_reg;
            r_mem_read     <= w_mem_read;
            r_mem_write    <= w_mem_write;
            r_mem_width    <= i_mem_width;
            r_mem_unsigned <= i_mem_unsigned;
            r_halt         <= r_halt | w_halt_set;
         end
      end
   end

   assign o_valid        = r_valid;
   assign o_register_rd  = r_register_rd;
   assign o_alu_result   = r_alu_result;
   assign o_rt_data      = r_rt_data;
   assign o_pc8          = r_pc8;
   assign o_reg_write    = r_reg_write;
   assign o_mem_to_reg   = r_mem_to_reg;
   assign o_mem_read     = r_mem_read;
   assign o_mem_write    = r_mem_write;
   assign o_mem_width    = r_mem_width;
   assign o_mem_unsigned = r_mem_unsigned;
   assign o_halt         = r_halt;

endmodule

// File: tb/tb_latch_ex_mem.sv
// -----------------------------------------------------------------------------
// tb_latch_ex_mem
//  Self-checking bench for latch_ex_mem: directed scenarios followed by
//  randomized traffic, all compared against a behavioural model of the
//  EX/MEM register's observable outputs.
// -----------------------------------------------------------------------------
module tb_latch_ex_mem;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] rt;
      logic [31:0] pc8;
      logic        rw;
      logic [1:0]  m2r;
      logic        mr;
      logic        mw;
      logic [1:0]  wid;
      logic        uns;
      logic        halt;
   } out_t;

   localparam int W = $bits(out_t);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT inputs ----------------
   logic        step, stall, flush, valid, reg_write, mem_read, mem_write, mem_unsigned, halt;
   logic [4:0]  rd;
   logic [31:0] alu, rt, pc8;
   logic [1:0]  mem_to_reg, mem_width;

   // ---------------- DUT outputs ----------------
   logic        o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_unsigned, o_halt;
   logic [4:0]  o_register_rd;
   logic [31:0] o_alu_result, o_rt_data, o_pc8;
   logic [1:0]  o_mem_to_reg, o_mem_width;

   latch_ex_mem dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_step(step), .i_stall(stall), .i_flush(flush),
      .i_valid(valid), .i_mux_register_rd(rd), .i_alu_result(alu), .i_rt_data(rt),
      .i_pc8(pc8), .i_reg_write(reg_write), .i_mem_to_reg(mem_to_reg),
      .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_width(mem_width),
      .i_mem_unsigned(mem_unsigned), .i_halt(halt),
      .o_valid(o_valid), .o_register_rd(o_register_rd), .o_alu_result(o_alu_result),
      .o_rt_data(o_rt_data), .o_pc8(o_pc8), .o_reg_write(o_reg_write),
      .o_mem_to_reg(o_mem_to_reg), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
      .o_mem_width(o_mem_width), .o_mem_unsigned(o_mem_unsigned), .o_halt(o_halt)
   );

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [W-1:0] exp_q[$];
   out_t        model;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input out_t e);
      check_val({tag, ".valid"},  32'(o_valid),        32'(e.valid));
      check_val({tag, ".rd"},     32'(o_register_rd),  32'(e.rd));
      check_val({tag, ".alu"},    o_alu_result,        e.alu);
      check_val({tag, ".rt"},     o_rt_data,           e.rt);
      check_val({tag, ".pc8"},    o_pc8,               e.pc8);
      check_val({tag, ".rw"},     32'(o_reg_write),    32'(e.rw));
      check_val({tag, ".m2r"},    32'(o_mem_to_reg),   32'(e.m2r));
      check_val({tag, ".mr"},     32'(o_mem_read),     32'(e.mr));
      check_val({tag, ".mw"},     32'(o_mem_write),    32'(e.mw));
      check_val({tag, ".wid"},    32'(o_mem_width),    32'(e.wid));
      check_val({tag, ".uns"},    32'(o_mem_unsigned), 32'(e.uns));
      check_val({tag, ".halt"},   32'(o_halt),         32'(e.halt));
   endtask

   // Reference behaviour of one rising edge given the current inputs.
   function automatic out_t model_edge(input out_t cur);
      out_t n;
      n = cur;
      if (!step) return cur;
      if (flush) begin
         n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 2'b00;
         n.alu = 0; n.rt = 0; n.pc8 = 0; n.rd = 0;
         return n;
      end
      if (stall) return cur;
      n.rd  = rd;
      n.alu = alu;
      n.rt  = rt;
      n.pc8 = pc8;
      n.m2r = mem_to_reg;
      n.wid = mem_width;
      n.uns = mem_unsigned;
      if (cur.halt || !valid) begin
         n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0;
      end else begin
         n.valid = 1;
         n.rw    = reg_write && (rd != 0);
         n.mw    = mem_write;
         n.mr    = mem_read && !mem_write;
      end
      n.halt = cur.halt || (halt && valid);
      return n;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      step = 1; stall = 0; flush = 0; valid = 0; rd = 0; alu = 0; rt = 0; pc8 = 0;
      reg_write = 0; mem_to_reg = 0; mem_read = 0; mem_write = 0; mem_width = 0;
      mem_unsigned = 0; halt = 0;
   endtask

   task automatic set_instr(input logic v, input logic [4:0] r, input logic [31:0] a,
                            input logic rw, input logic [1:0] m2r, input logic mr,
                            input logic mw, input logic h);
      valid = v; rd = r; alu = a; rt = $urandom; pc8 = $urandom;
      reg_write = rw; mem_to_reg = m2r; mem_read = mr; mem_write = mw;
      mem_width = 2'($urandom_range(0, 3)); mem_unsigned = 1'($urandom_range(0, 1)); halt = h;
   endtask

   // One rising edge; outputs are compared 1 time unit after it.
   task automatic tick(input string tag);
      @(posedge clk);
      model = model_edge(model);
      exp_q.push_back(model);
      #1;
      check_all(tag, out_t'(exp_q.pop_front()));
   endtask

   // Asynchronous reset asserted between edges, released away from the edge.
   task automatic mid_reset(input string tag);
      #2;
      rst_n = 0;
      #1;
      model = '0;
      check_all(tag, model);
      @(negedge clk);
      rst_n = 1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      set_idle();
      model = '0;
      #1;
      check_all("reset_init", model);
      @(negedge clk);
      rst_n = 1;

      // 1. reset mid-run
      set_instr(1, 5'd8, 32'hDEAD_BEEF, 1, 2'b00, 0, 0, 0);
      tick("t1_capture");
      check_val("t1_rd8", 32'(o_register_rd), 32'd8);
      mid_reset("t1_reset");

      // 2. normal load capture
      set_instr(1, 5'd9, 32'h0000_0010, 0, 2'b01, 1, 0, 0);
      tick("t2_load");
      check_val("t2_rd", 32'(o_register_rd), 32'd9);
      check_val("t2_alu", o_alu_result, 32'd16);
      check_val("t2_mr", 32'(o_mem_read), 32'd1);
      check_val("t2_valid", 32'(o_valid), 32'd1);

      // 3. $zero destination, then invalid instruction
      set_instr(1, 5'd0, 32'h1234, 1, 2'b00, 0, 0, 0);
      tick("t3_zero");
      check_val("t3_rw0", 32'(o_reg_write), 32'd0);
      check_val("t3_valid1", 32'(o_valid), 32'd1);
      set_instr(0, 5'd3, 32'h5678, 1, 2'b00, 0, 1, 0);
      tick("t3_invalid");
      check_val("t3_mw0", 32'(o_mem_write), 32'd0);
      check_val("t3_rw0b", 32'(o_reg_write), 32'd0);

      // load+store in one instruction -> store wins
      set_instr(1, 5'd4, 32'h40, 0, 2'b00, 1, 1, 0);
      tick("t3_rw_both");
      check_val("t3_both_mr", 32'(o_mem_read), 32'd0);

      // 4. stall then stall+flush
      set_instr(1, 5'd5, 32'h55, 1, 2'b00, 0, 0, 0);
      tick("t4_cap");
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         set_instr(1, 5'(10 + i), $urandom, 1, 2'b10, 0, 1, 0);
         tick("t4_stall");
         check_val("t4_hold_rd", 32'(o_register_rd), 32'd5);
      end
      flush = 1;
      tick("t4_flush");
      check_val("t4_bubble_valid", 32'(o_valid), 32'd0);
      check_val("t4_bubble_rd", 32'(o_register_rd), 32'd0);
      stall = 0; flush = 0;

      // 5. step gating
      set_instr(1, 5'd7, 32'h77, 1, 2'b00, 0, 0, 0);
      tick("t5_cap");
      step = 0; flush = 1;
      for (int i = 0; i < 4; i++) begin
         set_instr(1, 5'(20 + i), $urandom, 1, 2'b01, 1, 0, 1);
         tick("t5_gated");
         check_val("t5_hold_rd", 32'(o_register_rd), 32'd7);
      end
      step = 1; flush = 0;
      set_instr(1, 5'd12, 32'hC0DE, 1, 2'b00, 0, 0, 0);
      tick("t5_release");
      check_val("t5_rd", 32'(o_register_rd), 32'd12);

      // 6. sticky halt
      set_instr(1, 5'd1, 32'h1, 0, 2'b00, 0, 0, 1);
      tick("t6_halt");
      check_val("t6_halt1", 32'(o_halt), 32'd1);
      check_val("t6_halt_valid", 32'(o_valid), 32'd1);
      set_instr(1, 5'd2, 32'hABCD, 0, 2'b00, 0, 1, 0);
      tick("t6_store");
      check_val("t6_mw0", 32'(o_mem_write), 32'd0);
      check_val("t6_valid0", 32'(o_valid), 32'd0);
      check_val("t6_alu_upd", o_alu_result, 32'hABCD);
      check_val("t6_still", 32'(o_halt), 32'd1);
      flush = 1;
      tick("t6_flush");
      check_val("t6_flush_halt", 32'(o_halt), 32'd1);
      flush = 0;
      mid_reset("t6_reset");
      check_val("t6_halt0", 32'(o_halt), 32'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step  = ($urandom_range(0, 9) != 0);
         flush = ($urandom_range(0, 9) == 0);
         stall = ($urandom_range(0, 6) == 0);
         set_instr(1'($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 39) == 0));
         tick("rand");
         if ($urandom_range(0, 29) == 0) mid_reset("rand_reset");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
